vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Parametrised raster timing generator producing horizontal and vertical sync, display
//   enables, pixel coordinates and line/frame strobes from one clock plus a pixel-rate
//   enable. Sits between the clock/enable source and the pixel renderer; defaults give
//   640x480@60 with a 25 MHz pixel rate.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch, pixels
//   H_SYNC    96   horizontal sync pulse, pixels
//   H_BP      48   horizontal back porch, pixels
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch, lines
//   V_SYNC    2    vertical sync pulse, lines
//   V_BP      33   vertical back porch, lines
//   H_POL     0    h_sync asserted level (0 = active-low)
//   V_POL     0    v_sync asserted level (0 = active-low)
//   CW        10   width of x/y; must hold H_ACTIVE-1 and V_ACTIVE-1
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous reset, active-low
//   pix_en       in   1   pixel-rate step enable; tie 1 when clk is the pixel clock
//   h_sync       out  1   horizontal sync, polarity H_POL
//   v_sync       out  1   vertical sync, polarity V_POL
//   h_display    out  1   1 while h_cnt < H_ACTIVE
//   v_display    out  1   1 while v_cnt < V_ACTIVE
//   display      out  1   h_display & v_display
//   x            out  CW  h_cnt when h_display, else 0
//   y            out  CW  v_cnt when v_display, else 0
//   line_start   out  1   one-clk pulse, h_cnt has just become 0
//   frame_start  out  1   one-clk pulse, h_cnt and v_cnt have just become 0
// BEHAVIOUR
//   - H_TOTAL = sum of H_* regions; V_TOTAL likewise. Counter widths are $clog2(TOTAL).
//   - Region order per axis: active [0,ACT), front porch, sync [ACT+FP, ACT+FP+SYNC),
//     back porch. Sync asserted exactly over the sync range.
//   - On a clk edge with pix_en=1: h_cnt increments; at H_TOTAL-1 it wraps to 0 and
//     v_cnt advances (wrapping V_TOTAL-1 -> 0). pix_en=0: counters and outputs hold.
//   - All outputs are flops decoded from the next counter value, so they align with
//     the counters with zero extra latency. line_start/frame_start are high for
//     exactly one clk after the stepping edge, even if pix_en stays low afterwards.
//   - Vertical outputs change only at a line wrap, coincident with line_start.
//   - Reset (async assert, any time incl. mid-line): h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1;
//     h_sync=~H_POL, v_sync=~V_POL, h_display=v_display=display=0, x=y=0,
//     line_start=frame_start=0. First pix_en step after release gives (0,0),
//     display=1 and both strobes.
//   - Every region parameter >= 1; violations or CW too small stop elaboration
//     ($error in generate block).
// CONFIGURATION
//   VGA_TIMING_FRAME_COUNT_EN defined: adds output frame_count [15:0], reset 0,
//     incremented on the edge that raises frame_start (first frame after reset
//     reads 1), wraps 0xFFFF -> 0.
//   Undefined: port and counter absent; all other behaviour identical.
// TESTING
//   1 Defaults, pix_en=1: line_start every 800 clks; h_sync low for h_cnt 656..751
//     (96 clks); h_display high 640 clks per line.
//   2 Defaults: frame_start every 420000 clks; v_sync low for lines 490..491;
//     y reads 479 on last active line, 0 from line 480.
//   3 pix_en high every other clk: line period 1600 clks; strobes one clk wide;
//     outputs stable on pix_en=0 cycles.
//   4 H=4/1/1/1, V=2/1/1/1, H_POL=V_POL=1: h_sync high only at h_cnt 5, v_sync high
//     only on line 3, x runs 0..3, frame = 35 steps.
//   5 rst_n low at h_cnt=300,v_cnt=200: outputs take reset values immediately (async);
//     first step after release gives x=0,y=0,display=1,frame_start=1.
//   6 VGA_TIMING_FRAME_COUNT_EN, small config from 4: frame_count=1 after first
//     frame_start; force 0xFFFF -> next frame_start reads 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator (syncs, enables, x/y, line/frame strobes).
// Define VGA_TIMING_FRAME_COUNT_EN to add a wrapping 16-bit frame_count output.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          h_display,
  output logic          v_display,
  output logic          display,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HP = H_POL[0];
  localparam logic VP = V_POL[0];

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
      $error("vga_timing_gen: every timing region must be at least 1");
    end
    if (((H_ACTIVE - 1) >> CW) != 0 || ((V_ACTIVE - 1) >> CW) != 0) begin : g_bad_cw
      $error("vga_timing_gen: CW too small for the active area");
    end
  endgenerate

  logic [HW-1:0] r_h_cnt;
  logic [HW-1:0] w_h_nxt;
  logic [VW-1:0] r_v_cnt;
  logic [VW-1:0] w_v_nxt;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_hd;
  logic          w_vd;

  always_comb begin
    w_h_wrap = r_h_cnt == H_LAST;
    w_v_wrap = r_v_cnt == V_LAST;
    w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + 1'b1;
    w_v_nxt  = !w_h_wrap ? r_v_cnt : w_v_wrap ? '0 : r_v_cnt + 1'b1;
    w_hd     = w_h_nxt < H_ACT;
    w_vd     = w_v_nxt < V_ACT;
  end

  // Outputs are decoded from the next count so they line up with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt     <= H_LAST;
      r_v_cnt     <= V_LAST;
      h_sync      <= ~HP;
      v_sync      <= ~VP;
      h_display   <= 1'b0;
      v_display   <= 1'b0;
      display     <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en && w_h_wrap;
      frame_start <= pix_en && w_h_wrap && w_v_wrap;
      if (pix_en) begin
        r_h_cnt   <= w_h_nxt;
        r_v_cnt   <= w_v_nxt;
        h_sync    <= (w_h_nxt >= H_SS && w_h_nxt < H_SE) ? HP : ~HP;
        v_sync    <= (w_v_nxt >= V_SS && w_v_nxt < V_SE) ? VP : ~VP;
        h_display <= w_hd;
        v_display <= w_vd;
        display   <= w_hd && w_vd;
        x         <= w_hd ? CW'(w_h_nxt) : '0;
        y         <= w_vd ? CW'(w_v_nxt) : '0;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] r_frame_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_count <= '0;
    else if (pix_en && w_h_wrap && w_v_wrap) r_frame_count <= r_frame_count + 16'd1;
  end
  assign frame_count = r_frame_count;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks default, tiny and tall-frame configurations against an arithmetic raster model.
module tb_vga_timing_gen;
  typedef struct packed {
    logic hs, vs, hd, vd, de;
    logic [9:0] x, y;
    logic ls, fs;
  } out_t;
  typedef struct packed { int ha, hf, hsy, hb, va, vf, vsy, vb, hp, vp; } cfg_t;
  typedef struct packed { logic pe; out_t exp; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  int   n = 0;
  bit   st = 1'b0;
  int   total = 0;
  int   bad = 0;
  cfg_t cfg [3];
  vec_t tbl [9];

  always #5 clk = ~clk;

  logic hs0, vs0, hd0, vd0, de0, ls0, fs0;
  logic hs1, vs1, hd1, vd1, de1, ls1, fs1;
  logic hs2, vs2, hd2, vd2, de2, ls2, fs2;
  logic [9:0] x0, y0, x1, y1, x2, y2;
  out_t a0, a1, a2;
  assign a0 = {hs0, vs0, hd0, vd0, de0, x0, y0, ls0, fs0};
  assign a1 = {hs1, vs1, hd1, vd1, de1, x1, y1, ls1, fs1};
  assign a2 = {hs2, vs2, hd2, vd2, de2, x2, y2, ls2, fs2};
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] fc0, fc1, fc2;
  int off1 = 0;
`endif

  vga_timing_gen dut (
`ifdef VGA_TIMING_FRAME_COUNT_EN
    .frame_count(fc0),
`endif
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_sync(hs0), .v_sync(vs0),
    .h_display(hd0), .v_display(vd0), .display(de0), .x(x0), .y(y0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)) dut_s (
`ifdef VGA_TIMING_FRAME_COUNT_EN
    .frame_count(fc1),
`endif
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_sync(hs1), .v_sync(vs1),
    .h_display(hd1), .v_display(vd1), .display(de1), .x(x1), .y(y1),
    .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1)) dut_v (
`ifdef VGA_TIMING_FRAME_COUNT_EN
    .frame_count(fc2),
`endif
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_sync(hs2), .v_sync(vs2),
    .h_display(hd2), .v_display(vd2), .display(de2), .x(x2), .y(y2),
    .line_start(ls2), .frame_start(fs2)
  );

  function automatic out_t model(cfg_t c, int k, bit s);
    int ht, vt, h, v;
    out_t o;
    ht = c.ha + c.hf + c.hsy + c.hb;
    vt = c.va + c.vf + c.vsy + c.vb;
    o = '0;
    o.hs = !c.hp[0];
    o.vs = !c.vp[0];
    if (k == 0) return o;
    h = (k - 1) % ht;
    v = ((k - 1) / ht) % vt;
    o.hd = h < c.ha;
    o.vd = v < c.va;
    o.de = o.hd && o.vd;
    o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsy) ? c.hp[0] : !c.hp[0];
    o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsy) ? c.vp[0] : !c.vp[0];
    o.x = o.hd ? 10'(h) : 10'd0;
    o.y = o.vd ? 10'(v) : 10'd0;
    o.ls = s && h == 0;
    o.fs = s && h == 0 && v == 0;
    return o;
  endfunction

  function automatic int frames(cfg_t c, int k);
    int ft;
    ft = (c.ha + c.hf + c.hsy + c.hb) * (c.va + c.vf + c.vsy + c.vb);
    return k == 0 ? 0 : (k - 1) / ft + 1;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s n=%0d got=%h want=%h", nm, n, got, want);
    end
  endtask

  task automatic check_all();
    chk("dflt", a0, model(cfg[0], n, st));
    chk("small", a1, model(cfg[1], n, st));
    chk("tall", a2, model(cfg[2], n, st));
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("fc_dflt", fc0, 16'(frames(cfg[0], n)));
    chk("fc_small", fc1, 16'(frames(cfg[1], n) + off1));
    chk("fc_tall", fc2, 16'(frames(cfg[2], n)));
`endif
  endtask

  task automatic step(logic pe);
    pix_en = pe;
    @(posedge clk);
    st = pe && rst_n;
    if (st) n++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int ls_c, hsl_c, hd_c;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
    cfg[1] = '{4, 1, 1, 1, 2, 1, 1, 1, 1, 1};
    cfg[2] = '{4, 1, 1, 1, 480, 10, 2, 33, 0, 0};
    tbl[0] = '{1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1}};
    tbl[1] = '{1'b0, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0}};
    tbl[2] = '{1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0}};
    tbl[3] = '{1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd2, 10'd0, 1'b0, 1'b0}};
    tbl[4] = '{1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd3, 10'd0, 1'b0, 1'b0}};
    tbl[5] = '{1'b1, '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0}};
    tbl[6] = '{1'b1, '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0}};
    tbl[7] = '{1'b1, '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0}};
    tbl[8] = '{1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd1, 1'b1, 1'b0}};
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].pe);
      chk($sformatf("tbl%0d", i), a1, tbl[i].exp);
    end
    ls_c = 0;
    hsl_c = 0;
    hd_c = 0;
    for (int i = 0; i < 800; i++) begin
      step(1'b1);
      ls_c += int'(ls0);
      hsl_c += int'(!hs0);
      hd_c += int'(hd0);
    end
    chk("line_starts_per_800", ls_c, 1);
    chk("hsync_low_clks", hsl_c, 96);
    chk("hdisp_high_clks", hd_c, 640);
    for (int i = 0; i < 2000; i++) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < 1600; i++) step(1'(i % 2));
    for (int i = 0; i < 4000; i++) step(1'b1);
    for (int i = 0; i < 800 && (n - 1) % 800 != 300; i++) step(1'b1);
    chk("x_before_reset", x0, 300);
    #2 rst_n = 1'b0;
    n = 0;
    st = 1'b0;
    #1 check_all();
    @(negedge clk);
    step(1'b1);
    rst_n = 1'b1;
    step(1'b1);
    chk("post_reset_display", de0, 1);
    chk("post_reset_frame_start", fs0, 1);
    step(1'b0);
    chk("strobe_one_clk", fs0, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    for (int i = 0; i < 20; i++) step(1'b1);
    off1 = 16'hFFFF - frames(cfg[1], n);
    force dut_s.r_frame_count = 16'hFFFF;
    step(1'b0);
    release dut_s.r_frame_count;
    for (int i = 0; i < 40; i++) step(1'b1);
`endif
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
